// File: rtl/serial_deserializer_pkg.sv
// Shared frame geometry, FSM state type and symbol layout for the serial deserializer.
// Frames are three 9-bit symbols, each a K-code flag followed by 8 data bits.
package SerDeserializer;

   localparam int FRAME_W  = 27;
   localparam int SYM_W    = 9;
   localparam int NUM_SYM  = 3;
   localparam int BITCNT_W = $clog2(FRAME_W + 1);

   typedef enum logic {IDLE, SHIFT} deser_state_t;

   typedef struct packed {
      logic       k;
      logic [7:0] d;
   } symbol_t;

   // Gathers the K-code flag of every symbol; bit s belongs to symbol s.
   function automatic logic [NUM_SYM-1:0] get_kflags(input logic [FRAME_W-1:0] frame);
      logic [NUM_SYM-1:0] kf;
      symbol_t            sym;
      kf = '0;
      for (int s = 0; s < NUM_SYM; s++) begin
         sym   = frame[s*SYM_W +: SYM_W];
         kf[s] = sym.k;
      end
      return kf;
   endfunction

endpackage

// File: rtl/serial_deserializer_frame_fifo.sv
// frame_fifo: small synchronous FIFO with a registered head word and occupancy count.
// A push while full is accepted only when a pop happens in the same cycle.
module frame_fifo #(
   parameter int WIDTH = 27,
   parameter int DEPTH = 4
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         wdata_i,
   input  logic                     pop_i,
   output logic [WIDTH-1:0]         rdata_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   level_o
);
   localparam int              AW       = $clog2(DEPTH);
   localparam logic [AW:0]     FULL_LVL = (AW + 1)'(DEPTH);
   localparam logic [AW:0]     ONE_LVL  = (AW + 1)'(1);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_level;
   logic [WIDTH-1:0] r_head;

   logic             w_pop;
   logic             w_wr;
   logic [AW-1:0]    w_rd_next;
   logic             w_load_mem;
   logic             w_bypass;

   assign empty_o   = (r_level == '0);
   assign full_o    = (r_level == FULL_LVL);
   assign level_o   = r_level;
   assign rdata_o   = r_head;

   assign w_pop     = pop_i && !empty_o;
   assign w_wr      = push_i && (!full_o || w_pop);
   assign w_rd_next = w_pop ? r_rd_ptr + AW'(1) : r_rd_ptr;
   // The head only moves when it is consumed or when a write lands in the head slot.
   assign w_load_mem = w_pop && (r_level > ONE_LVL);
   assign w_bypass   = w_wr && ((r_level == '0) || ((r_level == ONE_LVL) && w_pop));

   always_ff @(posedge clk_i) begin
      if (w_wr) begin
         r_mem[r_wr_ptr] <= wdata_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
         r_head   <= '0;
      end else begin
         if (w_wr) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         r_rd_ptr <= w_rd_next;
         if (w_wr && !w_pop) begin
            r_level <= r_level + ONE_LVL;
         end else if (!w_wr && w_pop) begin
            r_level <= r_level - ONE_LVL;
         end
         if (w_bypass) begin
            r_head <= wdata_i;
         end else if (w_load_mem) begin
            r_head <= r_mem[w_rd_next];
         end
      end
   end

endmodule

// File: rtl/serial_deserializer.sv
// serial_deserializer: rebuilds 27-bit frames from an MSB-first serial stream into a valid/ready FIFO.
// Define DESER_STATS_EN to add saturating frame and runt counters.
module serial_deserializer
   import SerDeserializer::*;
#(
   parameter int DEPTH = 4,
   parameter int CNT_W = 16
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     data_i,
   input  logic                     ena_i,
   input  logic                     clr_i,
   output logic [FRAME_W-1:0]       frame_o,
   output logic [NUM_SYM-1:0]       kflags_o,
   output logic                     valid_o,
   input  logic                     ready_i,
   output logic                     runt_o,
   output logic                     ovf_o,
   output logic [$clog2(DEPTH):0]   level_o
`ifdef DESER_STATS_EN
   ,
   output logic [CNT_W-1:0]         frame_cnt_o,
   output logic [CNT_W-1:0]         runt_cnt_o
`endif
);
   localparam logic [BITCNT_W-1:0] LAST_BIT = BITCNT_W'(FRAME_W - 1);

   deser_state_t         r_state;
   deser_state_t         w_state_next;
   logic [BITCNT_W-1:0]  r_cnt;
   logic [BITCNT_W-1:0]  w_cnt_next;
   logic [FRAME_W-1:0]   r_shift;
   logic [FRAME_W-1:0]   w_shift_next;
   logic                 w_push_next;
   logic                 w_runt_next;
   logic                 r_push_q;
   logic [FRAME_W-1:0]   r_push_data;
   logic                 r_runt;
   logic                 r_ovf;

   logic                 w_empty;
   logic                 w_full;
   logic                 w_pop;
   logic                 w_drop;

   always_comb begin
      w_state_next = r_state;
      w_cnt_next   = r_cnt;
      w_shift_next = r_shift;
      w_push_next  = 1'b0;
      w_runt_next  = 1'b0;
      case (r_state)
         IDLE: begin
            if (ena_i) begin
               w_shift_next = {{(FRAME_W-1){1'b0}}, data_i};
               w_cnt_next   = BITCNT_W'(1);
               w_state_next = SHIFT;
            end
         end
         SHIFT: begin
            if (ena_i) begin
               w_shift_next = {r_shift[FRAME_W-2:0], data_i};
               if (r_cnt == LAST_BIT) begin
                  w_push_next = 1'b1;
                  w_cnt_next  = '0;
               end else begin
                  w_cnt_next  = r_cnt + BITCNT_W'(1);
               end
            end else begin
               w_runt_next  = (r_cnt != '0);
               w_shift_next = '0;
               w_cnt_next   = '0;
               w_state_next = IDLE;
            end
         end
         default: begin
            w_state_next = IDLE;
            w_cnt_next   = '0;
            w_shift_next = '0;
         end
      endcase
   end

   // The completed frame is captured separately so a back-to-back frame can start shifting at once.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_state     <= IDLE;
         r_cnt       <= '0;
         r_shift     <= '0;
         r_push_q    <= 1'b0;
         r_push_data <= '0;
         r_runt      <= 1'b0;
      end else begin
         r_state  <= w_state_next;
         r_cnt    <= w_cnt_next;
         r_shift  <= w_shift_next;
         r_push_q <= w_push_next;
         r_runt   <= w_runt_next;
         if (w_push_next) begin
            r_push_data <= w_shift_next;
         end
      end
   end

   frame_fifo #(
      .WIDTH (FRAME_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (r_push_q),
      .wdata_i (r_push_data),
      .pop_i   (w_pop),
      .rdata_o (frame_o),
      .full_o  (w_full),
      .empty_o (w_empty),
      .level_o (level_o)
   );

   assign valid_o  = !w_empty;
   assign w_pop    = valid_o && ready_i;
   assign w_drop   = r_push_q && w_full && !w_pop;
   assign kflags_o = get_kflags(frame_o);
   assign runt_o   = r_runt;
   assign ovf_o    = r_ovf;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_ovf <= 1'b0;
      end else if (w_drop) begin
         r_ovf <= 1'b1;
      end else if (clr_i) begin
         r_ovf <= 1'b0;
      end
   end

`ifdef DESER_STATS_EN
   logic [CNT_W-1:0] r_frame_cnt;
   logic [CNT_W-1:0] r_runt_cnt;

   // Every push attempt counts, including frames dropped on overflow.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_frame_cnt <= '0;
         r_runt_cnt  <= '0;
      end else if (clr_i) begin
         r_frame_cnt <= '0;
         r_runt_cnt  <= '0;
      end else begin
         if (r_push_q && (r_frame_cnt != '1)) begin
            r_frame_cnt <= r_frame_cnt + CNT_W'(1);
         end
         if (w_runt_next && (r_runt_cnt != '1)) begin
            r_runt_cnt <= r_runt_cnt + CNT_W'(1);
         end
      end
   end

   assign frame_cnt_o = r_frame_cnt;
   assign runt_cnt_o  = r_runt_cnt;
`endif

endmodule

// File: tb/tb_serial_deserializer.sv
// Self-checking bench for serial_deserializer: directed and random frames checked against a queue model.
// Builds with or without DESER_STATS_EN.
module tb_serial_deserializer;
   import SerDeserializer::*;

   localparam int DEPTH = 4;
   localparam int CNT_W = 16;
   localparam int LVL_W = $clog2(DEPTH) + 1;

   logic               clk_i = 1'b0;
   logic               rst_i;
   logic               data_i;
   logic               ena_i;
   logic               clr_i;
   logic               ready_i;
   logic [FRAME_W-1:0] frame_o;
   logic [NUM_SYM-1:0] kflags_o;
   logic               valid_o;
   logic               runt_o;
   logic               ovf_o;
   logic [LVL_W-1:0]   level_o;
`ifdef DESER_STATS_EN
   logic [CNT_W-1:0]   frame_cnt_o;
   logic [CNT_W-1:0]   runt_cnt_o;
`endif

   always #5 clk_i = ~clk_i;

   serial_deserializer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .data_i   (data_i),
      .ena_i    (ena_i),
      .clr_i    (clr_i),
      .frame_o  (frame_o),
      .kflags_o (kflags_o),
      .valid_o  (valid_o),
      .ready_i  (ready_i),
      .runt_o   (runt_o),
      .ovf_o    (ovf_o),
      .level_o  (level_o)
`ifdef DESER_STATS_EN
      ,
      .frame_cnt_o (frame_cnt_o),
      .runt_cnt_o  (runt_cnt_o)
`endif
   );

   int n_assert = 0;
   int n_fail   = 0;

   // Reference model: frames held by the FIFO, bits collected so far, and pending events.
   logic [FRAME_W-1:0] exp_q[$];
   logic [FRAME_W-1:0] m_acc = '0;
   int                 m_cnt = 0;
   bit                 m_pend = 0;
   logic [FRAME_W-1:0] m_pend_frame = '0;
   bit                 m_ovf = 0;
   bit                 m_runt = 0;
   int                 m_fcnt = 0;
   int                 m_rcnt = 0;
   bit                 cur_ready = 0;
   bit                 cur_clr = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One clock: check outputs at the falling edge, drive inputs, advance the model by one rising edge.
   task automatic step(input bit e, input bit d);
      logic [FRAME_W-1:0] head;
      bit pop, drop, runt_now;
      @(negedge clk_i);
      check("valid", {31'd0, valid_o}, (exp_q.size() != 0) ? 32'd1 : 32'd0);
      check("level", {{(32-LVL_W){1'b0}}, level_o}, exp_q.size());
      check("ovf", {31'd0, ovf_o}, {31'd0, m_ovf});
      check("runt", {31'd0, runt_o}, {31'd0, m_runt});
      if (exp_q.size() != 0) begin
         head = exp_q[0];
         check("frame", {5'd0, frame_o}, {5'd0, head});
         check("kflags", {29'd0, kflags_o}, {29'd0, head[26], head[17], head[8]});
      end
`ifdef DESER_STATS_EN
      check("frame_cnt", {16'd0, frame_cnt_o}, m_fcnt);
      check("runt_cnt", {16'd0, runt_cnt_o}, m_rcnt);
`endif
      ena_i   = e;
      data_i  = d;
      ready_i = cur_ready;
      clr_i   = cur_clr;

      pop  = (exp_q.size() != 0) && cur_ready;
      drop = m_pend && (exp_q.size() == DEPTH) && !pop;
      if (pop) begin
         $display("pop  frame %07h kflags %03b", exp_q[0], {exp_q[0][26], exp_q[0][17], exp_q[0][8]});
         void'(exp_q.pop_front());
      end
      if (m_pend && !drop) exp_q.push_back(m_pend_frame);
      if (drop) begin
         $display("drop frame %07h (fifo full)", m_pend_frame);
         m_ovf = 1;
      end else if (cur_clr) begin
         m_ovf = 0;
      end
      if (m_pend && m_fcnt < (2**CNT_W - 1)) m_fcnt++;
      runt_now = !e && (m_cnt > 0);
      if (runt_now && m_rcnt < (2**CNT_W - 1)) m_rcnt++;
      if (cur_clr) begin
         m_fcnt = 0;
         m_rcnt = 0;
      end
      m_runt = runt_now;
      if (runt_now) begin
         $display("runt after %0d bits", m_cnt);
         m_cnt = 0;
      end
      m_pend = 0;
      if (e) begin
         m_acc = (m_cnt == 0) ? {26'd0, d} : {m_acc[FRAME_W-2:0], d};
         m_cnt++;
         if (m_cnt == FRAME_W) begin
            m_pend       = 1;
            m_pend_frame = m_acc;
            m_cnt        = 0;
         end
      end
   endtask

   task automatic send_frame(input logic [FRAME_W-1:0] f, input int gap);
      for (int i = FRAME_W - 1; i >= 0; i--) step(1'b1, f[i]);
      for (int g = 0; g < gap; g++) step(1'b0, 1'b0);
   endtask

   task automatic send_bits(input int n);
      for (int i = 0; i < n; i++) step(1'b1, 1'($urandom_range(0, 1)));
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0);
   endtask

   task automatic do_reset();
      @(negedge clk_i);
      rst_i   = 1'b0;
      ena_i   = 1'b0;
      data_i  = 1'b0;
      clr_i   = 1'b0;
      cur_clr = 0;
      #1;
      check("rst_valid", {31'd0, valid_o}, 32'd0);
      check("rst_level", {{(32-LVL_W){1'b0}}, level_o}, 32'd0);
      check("rst_frame", {5'd0, frame_o}, 32'd0);
      check("rst_kflags", {29'd0, kflags_o}, 32'd0);
      check("rst_runt", {31'd0, runt_o}, 32'd0);
      check("rst_ovf", {31'd0, ovf_o}, 32'd0);
`ifdef DESER_STATS_EN
      check("rst_frame_cnt", {16'd0, frame_cnt_o}, 32'd0);
      check("rst_runt_cnt", {16'd0, runt_cnt_o}, 32'd0);
`endif
      exp_q.delete();
      m_cnt  = 0;
      m_pend = 0;
      m_ovf  = 0;
      m_runt = 0;
      m_fcnt = 0;
      m_rcnt = 0;
      @(negedge clk_i);
      check("rst_hold_runt", {31'd0, runt_o}, 32'd0);
      rst_i = 1'b1;
      $display("reset released");
   endtask

   initial begin
      logic [FRAME_W-1:0] f;
      rst_i   = 1'b0;
      data_i  = 1'b0;
      ena_i   = 1'b0;
      clr_i   = 1'b0;
      ready_i = 1'b0;
      do_reset();
      idle(2);

      // Single frame, consumer always ready: valid two edges after the last bit edge, then popped.
      cur_ready = 1;
      send_frame(27'h5A5A5A5, 0);
      step(1'b0, 1'b0);
      check("lat_valid_low", {31'd0, valid_o}, 32'd0);
      step(1'b0, 1'b0);
      check("lat_valid_high", {31'd0, valid_o}, 32'd1);
      check("lat_frame", {5'd0, frame_o}, 32'h05A5A5A5);
      idle(3);
      check("single_level0", {{(32-LVL_W){1'b0}}, level_o}, 32'd0);

      // K-code frame.
      f = {9'h1BC, 9'h0AA, 9'h155};
      cur_ready = 0;
      send_frame(f, 3);
      check("kcode_kflags", {29'd0, kflags_o}, 32'd5);
      cur_ready = 1;
      idle(3);

      // Runt after 13 bits, then a normal frame.
      send_bits(13);
      idle(2);
      check("runt_pulse", {31'd0, runt_o}, 32'd1);
      idle(1);
      check("runt_end", {31'd0, runt_o}, 32'd0);
      check("runt_level", {{(32-LVL_W){1'b0}}, level_o}, 32'd0);
      send_frame(27'h0000001, 4);

      // Random frames with random gaps and consumer stalls, including back-to-back.
      for (int n = 0; n < 8; n++) begin
         cur_ready = ($urandom_range(0, 3) != 0);
         send_frame(27'($urandom), $urandom_range(0, 2));
      end
      cur_ready = 1;
      idle(10);
      cur_clr = 1;
      idle(1);
      cur_clr = 0;
      idle(1);

      // Overflow: five back-to-back frames with no consumer.
      cur_ready = 0;
      for (int n = 0; n < 5; n++) send_frame(27'($urandom), 0);
      idle(3);
      check("ovf_level", {{(32-LVL_W){1'b0}}, level_o}, 32'd4);
      check("ovf_set", {31'd0, ovf_o}, 32'd1);
      // Push while full, with a pop on the very same edge.
      send_frame(27'($urandom), 0);
      cur_ready = 1;
      step(1'b0, 1'b0);
      cur_ready = 0;
      idle(1);
      check("full_push_pop_level", {{(32-LVL_W){1'b0}}, level_o}, 32'd4);
      cur_ready = 1;
      idle(8);

      // Clear the sticky overflow flag; an idle FIFO must stay untouched.
      cur_clr = 1;
      idle(1);
      cur_clr = 0;
      idle(1);
      check("clr_ovf", {31'd0, ovf_o}, 32'd0);

      // Reset in the middle of a frame while the FIFO holds a frame.
      cur_ready = 0;
      send_frame(27'($urandom), 2);
      send_bits(10);
      do_reset();
      idle(2);
      cur_ready = 1;
      send_frame(27'($urandom), 4);

`ifdef DESER_STATS_EN
      cur_clr = 1;
      idle(1);
      cur_clr = 0;
      for (int n = 0; n < 3; n++) send_frame(27'($urandom), 2);
      send_bits(5);
      idle(2);
      send_bits(20);
      idle(3);
      check("stats_frames", {16'd0, frame_cnt_o}, 32'd3);
      check("stats_runts", {16'd0, runt_cnt_o}, 32'd2);
      cur_clr = 1;
      idle(1);
      cur_clr = 0;
      idle(1);
      check("stats_clr_frames", {16'd0, frame_cnt_o}, 32'd0);
      check("stats_clr_runts", {16'd0, runt_cnt_o}, 32'd0);
`endif

      idle(4);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
